writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/writeback_stage.sv | 113 +++++++++++
 tb/tb_writeback_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Purpose : MEM/WB pipeline register plus write-back mux, forwarding compare,
//           registered output port and retired-instruction counter.
// Latency : one cycle from MEM inputs to regWrite/WD/WA; fwd_* and WD are
//           combinational from the register.
// Backpressure: stall holds the register (write stays asserted);
//           flush squashes it; rst overrides both.
// Ports   : clk/rst (sync, active-high); in_valid, stall, flush, WB_signals,
//           out_en, ALU_result, mem_data, in_port, pc_plus1, dst from MEM;
//           src_q/dst_q from Decode; regWrite/WD/WA, fwd_src/fwd_dst to Decode;
//           out_port external output; retired instruction count.
module writeback_stage #(
   parameter int W = 16,
   parameter int N = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic          stall,
   input  logic          flush,
   input  logic [2:0]    WB_signals,
   input  logic          out_en,
   input  logic [W-1:0]  ALU_result,
   input  logic [W-1:0]  mem_data,
   input  logic [W-1:0]  in_port,
   input  logic [W-1:0]  pc_plus1,
   input  logic [N-1:0]  dst,
   input  logic [N-1:0]  src_q,
   input  logic [N-1:0]  dst_q,
   output logic          regWrite,
   output logic [W-1:0]  WD,
   output logic [N-1:0]  WA,
   output logic          fwd_src,
   output logic          fwd_dst,
   output logic [W-1:0]  out_port,
   output logic [15:0]   retired
);

   // MEM/WB register fields
   logic          wb_valid;
   logic          wb_reg_write;
   logic [1:0]    wb_sel;
   // Kept in the stage for visibility; the output port is loaded at capture
   // time, so nothing downstream reads the stored copy.
   logic          wb_out_en_unused;
   logic [W-1:0]  wb_alu;
   logic [W-1:0]  wb_mem;
   logic [W-1:0]  wb_inp;
   logic [W-1:0]  wb_pc;
   logic [N-1:0]  wb_dst;

   logic          capture;

   // A capture edge is one with neither rst, flush nor stall.
   assign capture = !flush && !stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_valid         <= 1'b0;
         wb_reg_write     <= 1'b0;
         wb_sel           <= 2'b00;
         wb_out_en_unused <= 1'b0;
         wb_alu           <= '0;
         wb_mem           <= '0;
         wb_inp           <= '0;
         wb_pc            <= '0;
         wb_dst           <= '0;
      end else if (flush) begin
         // Only valid matters after a squash; the data fields just hold.
         wb_valid <= 1'b0;
      end else if (!stall) begin
         wb_valid         <= in_valid;
         wb_reg_write     <= WB_signals[2];
         wb_sel           <= WB_signals[1:0];
         wb_out_en_unused <= out_en;
         wb_alu           <= ALU_result;
         wb_mem           <= mem_data;
         wb_inp           <= in_port;
         wb_pc            <= pc_plus1;
         wb_dst           <= dst;
      end
   end

   // Output port and retire counter only move on capture edges with a
   // valid instruction; flush/stall edges leave them untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_port <= '0;
         retired  <= 16'd0;
      end else if (capture && in_valid) begin
         retired <= retired + 16'd1;
         if (out_en) begin
            out_port <= ALU_result;
         end
      end
   end

   assign regWrite = wb_valid & wb_reg_write;
   assign WA       = wb_dst;

   always_comb begin
      WD = wb_alu;
      unique case (wb_sel)
         2'b00:   WD = wb_alu;
         2'b01:   WD = wb_mem;
         2'b10:   WD = wb_inp;
         default: WD = wb_pc;
      endcase
   end

   assign fwd_src = regWrite && (WA == src_q);
   assign fwd_dst = regWrite && (WA == dst_q);

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;
   localparam int W = 16;
   localparam int N = 3;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          stall;
   logic          flush;
   logic [2:0]    WB_signals;
   logic          out_en;
   logic [W-1:0]  ALU_result;
   logic [W-1:0]  mem_data;
   logic [W-1:0]  in_port;
   logic [W-1:0]  pc_plus1;
   logic [N-1:0]  dst;
   logic [N-1:0]  src_q;
   logic [N-1:0]  dst_q;
   logic          regWrite;
   logic [W-1:0]  WD;
   logic [N-1:0]  WA;
   logic          fwd_src;
   logic          fwd_dst;
   logic [W-1:0]  out_port;
   logic [15:0]   retired;

   int errors = 0;
   int checks = 0;

   writeback_stage #(.W(W), .N(N)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
      .WB_signals(WB_signals), .out_en(out_en), .ALU_result(ALU_result),
      .mem_data(mem_data), .in_port(in_port), .pc_plus1(pc_plus1), .dst(dst),
      .src_q(src_q), .dst_q(dst_q), .regWrite(regWrite), .WD(WD), .WA(WA),
      .fwd_src(fwd_src), .fwd_dst(fwd_dst), .out_port(out_port),
      .retired(retired)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- behavioural model ----------------
   // The instruction currently sitting in write-back, as a record.
   typedef struct {
      bit        valid;
      bit        writes;
      bit [1:0]  kind;     // 0 alu, 1 load, 2 input, 3 call
      bit [15:0] alu, mem, inp, pc;
      bit [2:0]  dst;
      bit        dst_known;
   } instr_t;

   instr_t    m;
   bit [15:0] m_port;
   int        m_count;     // unbounded count; retired is it mod 65536
   bit        started = 1'b0;

   function automatic bit [15:0] result_of(instr_t i);
      bit [15:0] vals [4];
      vals[0] = i.alu; vals[1] = i.mem; vals[2] = i.inp; vals[3] = i.pc;
      return vals[i.kind];
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m = '{default: 0};
         m.dst_known = 1'b1;
         m_port  = 16'h0;
         m_count = 0;
         started = 1'b1;
      end else if (flush) begin
         m.valid = 1'b0;
         m.dst_known = 1'b0;
      end else if (!stall) begin
         m.valid  = in_valid;
         m.writes = WB_signals[2];
         m.kind   = WB_signals[1:0];
         m.alu = ALU_result; m.mem = mem_data; m.inp = in_port; m.pc = pc_plus1;
         m.dst = dst;
         m.dst_known = 1'b1;
         if (in_valid) begin
            m_count++;
            if (out_en) m_port = ALU_result;
         end
      end
   end

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Continuous comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (started) begin
         bit wr;
         wr = m.valid && m.writes;
         cmp("regWrite", {31'd0, regWrite}, {31'd0, wr});
         if (wr) cmp("WD", {16'd0, WD}, {16'd0, result_of(m)});
         if (m.dst_known) cmp("WA", {29'd0, WA}, {29'd0, m.dst});
         cmp("fwd_src", {31'd0, fwd_src}, {31'd0, wr && (m.dst == src_q)});
         cmp("fwd_dst", {31'd0, fwd_dst}, {31'd0, wr && (m.dst == dst_q)});
         cmp("out_port", {16'd0, out_port}, {16'd0, m_port});
         cmp("retired", {16'd0, retired}, m_count & 32'hFFFF);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 0; stall = 0; flush = 0; rst = 0;
   endtask

   task automatic issue(input logic [2:0] wb, input logic oe, input logic [15:0] alu,
                        input logic [15:0] md, input logic [15:0] ip,
                        input logic [15:0] pc, input logic [2:0] d);
      in_valid = 1; WB_signals = wb; out_en = oe; ALU_result = alu;
      mem_data = md; in_port = ip; pc_plus1 = pc; dst = d;
   endtask

   initial begin
      rst = 1; in_valid = 0; stall = 0; flush = 0; WB_signals = 0; out_en = 0;
      ALU_result = 0; mem_data = 0; in_port = 0; pc_plus1 = 0; dst = 0;
      src_q = 0; dst_q = 0;
      tick(); tick();
      // reset state
      cmp("rst_regWrite", {31'd0, regWrite}, 0);
      cmp("rst_WA", {29'd0, WA}, 0);
      cmp("rst_fwd_src", {31'd0, fwd_src}, 0);
      cmp("rst_out_port", {16'd0, out_port}, 0);
      cmp("rst_retired", {16'd0, retired}, 0);
      idle();

      // capture
      issue(3'b100, 0, 16'h1234, 16'h0, 16'h0, 16'h0, 3'd5);
      tick();
      cmp("cap_regWrite", {31'd0, regWrite}, 1);
      cmp("cap_WA", {29'd0, WA}, 5);
      cmp("cap_WD", {16'd0, WD}, 32'h1234);
      cmp("cap_retired", {16'd0, retired}, 1);

      // mux: load then call
      issue(3'b101, 0, 16'h1111, 16'hBEEF, 16'h2222, 16'h3333, 3'd1);
      tick();
      cmp("mux_load", {16'd0, WD}, 32'hBEEF);
      issue(3'b111, 0, 16'h1111, 16'h4444, 16'h2222, 16'h0042, 3'd7);
      tick();
      cmp("mux_call", {16'd0, WD}, 32'h0042);
      issue(3'b110, 0, 16'h1111, 16'h4444, 16'hC0DE, 16'h0042, 3'd6);
      tick();
      cmp("mux_in", {16'd0, WD}, 32'hC0DE);

      // stall / flush
      issue(3'b101, 0, 16'h0, 16'h5555, 16'h0, 16'h0, 3'd3);
      tick();
      issue(3'b100, 0, 16'h9999, 16'h0, 16'h0, 16'h0, 3'd6);
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         cmp("stall_WD", {16'd0, WD}, 32'h5555);
         cmp("stall_WA", {29'd0, WA}, 3);
         cmp("stall_regWrite", {31'd0, regWrite}, 1);
         cmp("stall_retired", {16'd0, retired}, 5);
      end
      flush = 1;
      tick();
      cmp("stallflush_regWrite", {31'd0, regWrite}, 0);
      cmp("stallflush_retired", {16'd0, retired}, 5);
      idle();

      // forwarding
      src_q = 3'd2; dst_q = 3'd4;
      issue(3'b100, 0, 16'h7, 16'h0, 16'h0, 16'h0, 3'd2);
      tick();
      cmp("fwd_src_hit", {31'd0, fwd_src}, 1);
      cmp("fwd_dst_miss", {31'd0, fwd_dst}, 0);
      issue(3'b000, 0, 16'h7, 16'h0, 16'h0, 16'h0, 3'd2);
      tick();
      cmp("fwd_src_nowr", {31'd0, fwd_src}, 0);
      cmp("fwd_dst_nowr", {31'd0, fwd_dst}, 0);

      // output port
      issue(3'b000, 1, 16'h00FF, 16'h0, 16'h0, 16'h0, 3'd0);
      tick();
      cmp("port_load", {16'd0, out_port}, 32'h00FF);
      issue(3'b000, 1, 16'hAAAA, 16'h0, 16'h0, 16'h0, 3'd0);
      flush = 1;
      for (int i = 0; i < 5; i++) begin
         tick();
         cmp("port_flush_hold", {16'd0, out_port}, 32'h00FF);
      end
      flush = 0; rst = 1;
      tick();
      cmp("port_rst", {16'd0, out_port}, 0);
      idle();

      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         rst   = ($urandom_range(63) == 0);
         flush = ($urandom_range(7) == 0);
         stall = ($urandom_range(3) == 0);
         in_valid   = ($urandom_range(3) != 0);
         WB_signals = 3'($urandom);
         out_en     = $urandom_range(1);
         ALU_result = 16'($urandom);
         mem_data   = 16'($urandom);
         in_port    = 16'($urandom);
         pc_plus1   = 16'($urandom);
         dst        = 3'($urandom);
         src_q      = 3'($urandom);
         dst_q      = 3'($urandom);
         tick();
      end

      // counter wrap
      idle();
      rst = 1;
      tick();
      idle();
      issue(3'b100, 0, 16'h1, 16'h0, 16'h0, 16'h0, 3'd1);
      for (int i = 0; i < 65535; i++) tick();
      cmp("wrap_ffff", {16'd0, retired}, 32'hFFFF);
      tick();
      cmp("wrap_zero", {16'd0, retired}, 0);
      tick(); tick();
      rst = 1;
      tick();
      cmp("midrst_retired", {16'd0, retired}, 0);
      cmp("midrst_regWrite", {31'd0, regWrite}, 0);
      idle();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
